// File: rtl/tmem_read_responder_if.sv
// tmem_read_responder_if: request/response and backing-memory signals of the TMEM read responder
interface tmem_read_responder_if #(
    parameter int NUM_CORES = 4,
    parameter int DATA_W = 96,
    parameter int ADDR_W = 16
);
    logic [NUM_CORES*DATA_W-1:0] read_address;
    logic [NUM_CORES-1:0] data_request;
    logic [DATA_W-1:0] read_data;
    logic [NUM_CORES-1:0] data_available;
    logic [ADDR_W-1:0] mem_address;
    logic mem_read_enable;
    logic [DATA_W-1:0] mem_data;
    logic mem_data_valid;
    logic timeout_error;
    modport slave (
        input read_address, data_request, mem_data, mem_data_valid,
        output read_data, data_available, mem_address, mem_read_enable, timeout_error
    );
    modport master (
        output read_address, data_request, mem_data, mem_data_valid,
        input read_data, data_available, mem_address, mem_read_enable, timeout_error
    );
endinterface

// File: rtl/tmem_read_responder.sv
// tmem_read_responder: round-robin TMEM read arbiter with one outstanding memory read and timeout
module tmem_read_responder #(
    parameter int NUM_CORES = 4,
    parameter int DATA_W = 96,
    parameter int ADDR_W = 16,
    parameter int TIMEOUT = 64
) (
    input logic clk,
    input logic rst,
    tmem_read_responder_if.slave bus
);
    localparam int IW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
    localparam int CW = $clog2(TIMEOUT);
    typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;
    state_t state, state_n;
    logic [IW-1:0] grant, grant_n, last, last_n, pick;
    logic [CW-1:0] cnt, cnt_n;
    logic [DATA_W-1:0] data_q, data_n, rd_n;
    logic [NUM_CORES-1:0] holdoff, holdoff_n, eligible, avail_n;
    logic [ADDR_W-1:0] addr_n;
    logic to_q, to_n, re_n, terr_n, found;
    logic unused;
    assign unused = ^bus.read_address;
    always_comb begin
        eligible = bus.data_request & ~holdoff;
        pick = last;
        found = 1'b0;
        for (int k = 1; k <= NUM_CORES; k++) begin
            if (!found && eligible[(int'(last) + k) % NUM_CORES]) begin
                found = 1'b1;
                pick = IW'((int'(last) + k) % NUM_CORES);
            end
        end
    end
    always_comb begin
        state_n = state;
        grant_n = grant;
        cnt_n = cnt;
        data_n = data_q;
        to_n = to_q;
        last_n = last;
        holdoff_n = '0;
        rd_n = bus.read_data;
        avail_n = '0;
        re_n = 1'b0;
        terr_n = 1'b0;
        addr_n = bus.mem_address;
        case (state)
            IDLE: begin
                if (found) begin
                    state_n = WAIT;
                    grant_n = pick;
                    addr_n = bus.read_address[int'(pick)*DATA_W +: ADDR_W];
                    re_n = 1'b1;
                    cnt_n = '0;
                    to_n = 1'b0;
                end
            end
            WAIT: begin
                cnt_n = cnt + 1'b1;
                if (bus.mem_data_valid) begin
                    data_n = bus.mem_data;
                    state_n = RESPOND;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    data_n = '0;
                    to_n = 1'b1;
                    state_n = RESPOND;
                end
            end
            RESPOND: begin
                // an aborted requester still costs a slot but receives no strobe
                rd_n = data_q;
                avail_n[grant] = bus.data_request[grant];
                terr_n = to_q;
                last_n = grant;
                holdoff_n[grant] = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            grant <= '0;
            last <= IW'(NUM_CORES - 1);
            cnt <= '0;
            data_q <= '0;
            to_q <= 1'b0;
            holdoff <= '0;
            bus.read_data <= '0;
            bus.data_available <= '0;
            bus.mem_address <= '0;
            bus.mem_read_enable <= 1'b0;
            bus.timeout_error <= 1'b0;
        end else begin
            state <= state_n;
            grant <= grant_n;
            last <= last_n;
            cnt <= cnt_n;
            data_q <= data_n;
            to_q <= to_n;
            holdoff <= holdoff_n;
            bus.read_data <= rd_n;
            bus.data_available <= avail_n;
            bus.mem_address <= addr_n;
            bus.mem_read_enable <= re_n;
            bus.timeout_error <= terr_n;
        end
    end
endmodule

// File: tb/tb_tmem_read_responder.sv
// tb_tmem_read_responder: directed scoreboard bench with a latency-programmable memory model
module tb_tmem_read_responder;
    localparam int NC = 4;
    localparam int DW = 96;
    localparam int AW = 16;
    localparam int TO = 64;
    typedef struct {
        logic [NC-1:0] avail;
        logic [DW-1:0] data;
        logic terr;
        int lat;
    } rsp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;
    tmem_read_responder_if #(.NUM_CORES(NC), .DATA_W(DW), .ADDR_W(AW)) bus();
    tmem_read_responder #(.NUM_CORES(NC), .DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    rsp_t exp_rsp[$];
    logic [AW-1:0] exp_addr[$];
    logic [AW-1:0] rd_addr = '0;
    int tests = 0, fails = 0, cyc = 0, re_cyc = 0, cd = 0, mem_lat = 2;
    bit mem_on = 1'b1, inj = 1'b0;
    function automatic logic [DW-1:0] mdata(logic [AW-1:0] a);
        return a == 16'h0010 ? 96'hAAAA_BBBB_CCCC : {a, 16'h5A5A, a, 16'hC3C3, a, ~a};
    endfunction
    task automatic chk(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic expect_txn(int c, logic [AW-1:0] a, bit rsp, bit to, int lat);
        rsp_t e;
        exp_addr.push_back(a);
        e.avail = NC'(1) << c;
        e.data = to ? '0 : mdata(a);
        e.terr = to;
        e.lat = lat;
        if (rsp) exp_rsp.push_back(e);
    endtask
    task automatic set_addr(int c, logic [AW-1:0] a);
        bus.read_address[c*DW +: DW] = DW'(a);
    endtask
    task automatic wait_strobe(int c);
        bit got = 1'b0;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            got = bus.data_available[c];
        end
        chk($sformatf("strobe_core%0d", c), DW'(got), DW'(1));
    endtask
    task automatic wait_read();
        for (int i = 0; i < 100 && exp_addr.size() != 0; i++) @(negedge clk);
        chk("read_issued", DW'(exp_addr.size()), DW'(0));
    endtask
    task automatic drain(int n);
        repeat (n) @(negedge clk);
        chk("queues_drained", DW'(exp_addr.size() + exp_rsp.size()), DW'(0));
    endtask
    task automatic chk_zero(string tag);
        chk({tag, "_read_data"}, bus.read_data, '0);
        chk({tag, "_avail"}, DW'(bus.data_available), '0);
        chk({tag, "_mem_address"}, DW'(bus.mem_address), '0);
        chk({tag, "_read_enable"}, DW'(bus.mem_read_enable), '0);
        chk({tag, "_timeout_error"}, DW'(bus.timeout_error), '0);
    endtask
    // memory model and response scoreboard
    always @(negedge clk) begin
        rsp_t e;
        cyc++;
        bus.mem_data_valid = inj;
        bus.mem_data = inj ? {DW{1'b1}} : '0;
        if (cd > 0) begin
            cd--;
            if (cd == 0) begin
                bus.mem_data_valid = 1'b1;
                bus.mem_data = mdata(rd_addr);
            end
        end
        if (bus.mem_read_enable) begin
            chk("read_expected", DW'(exp_addr.size() != 0), DW'(1));
            if (exp_addr.size() != 0) chk("mem_address", DW'(bus.mem_address), DW'(exp_addr.pop_front()));
            rd_addr = bus.mem_address;
            re_cyc = cyc;
            cd = mem_on ? mem_lat : 0;
        end
        if (bus.data_available != '0 || bus.timeout_error) begin
            chk("response_expected", DW'(exp_rsp.size() != 0), DW'(1));
            if (exp_rsp.size() != 0) begin
                e = exp_rsp.pop_front();
                chk("avail", DW'(bus.data_available), DW'(e.avail));
                chk("read_data", bus.read_data, e.data);
                chk("timeout_error", DW'(bus.timeout_error), DW'(e.terr));
                chk("latency", DW'(cyc - re_cyc), DW'(e.lat));
            end
        end
    end
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.data_request = '0;
        bus.read_address = '0;
        repeat (3) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        // single request, holding one cycle past the strobe
        mem_lat = 2;
        expect_txn(0, 16'h0010, 1'b1, 1'b0, 4);
        set_addr(0, 16'h0010);
        bus.data_request[0] = 1'b1;
        wait_strobe(0);
        chk("single_data", bus.read_data, 96'hAAAA_BBBB_CCCC);
        @(posedge clk);
        #1 bus.data_request[0] = 1'b0;
        drain(10);
        // round robin from a fresh reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rr_reset_read_data", bus.read_data, '0);
        mem_lat = 3;
        for (int i = 0; i < NC; i++) set_addr(i, AW'(16'h100 + i));
        for (int n = 0; n < 8; n++) expect_txn(n % NC, AW'(16'h100 + n % NC), 1'b1, 1'b0, 5);
        bus.data_request = '1;
        for (int n = 0; n < 8; n++) begin
            wait_strobe(n % NC);
            if (n >= 4) begin
                @(posedge clk);
                #1 bus.data_request[n % NC] = 1'b0;
            end
        end
        drain(10);
        // wrap-around: last served 2, cores 0 and 3 together
        mem_lat = 1;
        expect_txn(2, 16'h0222, 1'b1, 1'b0, 3);
        set_addr(2, 16'h0222);
        bus.data_request[2] = 1'b1;
        wait_strobe(2);
        expect_txn(3, 16'h0333, 1'b1, 1'b0, 3);
        expect_txn(0, 16'h0300, 1'b1, 1'b0, 3);
        set_addr(0, 16'h0300);
        set_addr(3, 16'h0333);
        @(posedge clk);
        #1 bus.data_request[2] = 1'b0;
        bus.data_request[0] = 1'b1;
        bus.data_request[3] = 1'b1;
        wait_strobe(3);
        @(posedge clk);
        #1 bus.data_request[3] = 1'b0;
        wait_strobe(0);
        @(posedge clk);
        #1 bus.data_request[0] = 1'b0;
        drain(10);
        // timeout, then a late valid that must be dropped
        mem_on = 1'b0;
        expect_txn(1, 16'h0777, 1'b1, 1'b1, TO + 1);
        set_addr(1, 16'h0777);
        bus.data_request[1] = 1'b1;
        wait_strobe(1);
        chk("timeout_pulse", DW'(bus.timeout_error), DW'(1));
        @(posedge clk);
        #1 bus.data_request[1] = 1'b0;
        @(posedge clk);
        #1 inj = 1'b1;
        @(posedge clk);
        #1 inj = 1'b0;
        mem_on = 1'b1;
        drain(10);
        // abort during WAIT, next core served normally
        mem_lat = 6;
        expect_txn(1, 16'h0123, 1'b0, 1'b0, 0);
        set_addr(1, 16'h0123);
        bus.data_request[1] = 1'b1;
        wait_read();
        #1 bus.data_request[1] = 1'b0;
        expect_txn(2, 16'h0222, 1'b1, 1'b0, 8);
        bus.data_request[2] = 1'b1;
        wait_strobe(2);
        @(posedge clk);
        #1 bus.data_request[2] = 1'b0;
        drain(10);
        // serve core 0 so a missing pointer reset would favour core 2 below
        mem_lat = 2;
        expect_txn(0, 16'h0040, 1'b1, 1'b0, 4);
        set_addr(0, 16'h0040);
        bus.data_request[0] = 1'b1;
        wait_strobe(0);
        @(posedge clk);
        #1 bus.data_request[0] = 1'b0;
        drain(5);
        // reset mid-WAIT
        mem_on = 1'b0;
        expect_txn(1, 16'h0456, 1'b0, 1'b0, 0);
        set_addr(1, 16'h0456);
        bus.data_request[1] = 1'b1;
        wait_read();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        bus.data_request[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        chk_zero("midwait_reset");
        mem_on = 1'b1;
        expect_txn(0, 16'h0500, 1'b1, 1'b0, 4);
        expect_txn(2, 16'h0520, 1'b1, 1'b0, 4);
        set_addr(0, 16'h0500);
        set_addr(2, 16'h0520);
        bus.data_request[0] = 1'b1;
        bus.data_request[2] = 1'b1;
        wait_strobe(0);
        @(posedge clk);
        #1 bus.data_request[0] = 1'b0;
        wait_strobe(2);
        @(posedge clk);
        #1 bus.data_request[2] = 1'b0;
        drain(10);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/tmem_read_responder.md
Name: tmem_read_responder

Overview:
Texture-memory (TMEM) responder that services the read-request interface driven by the execution units' IO stations. It arbitrates round-robin among up to NUM_CORES requesters and issues one read to the backing texture SRAM/controller. It returns the data row on a shared bus together with a one-cycle per-core data-available strobe. A timeout guarantees that no requester hangs on a dead memory.

Parameters:
NUM_CORES, 4, number of execution units served (1..8)
DATA_W, 96, data row width (`DATA_ROW_WIDTH)
ADDR_W, 16, backing-memory address width; the low ADDR_W bits of each request address are used
TIMEOUT, 64, max cycles to wait for iMemDataValid after a memory read is issued (>=2)

Ports:
Clock  in  1  system clock
Reset  in  1  synchronous, active-high reset
iTMEMReadAddress  in  NUM_CORES*DATA_W  per-core request address, core i at slice [i*DATA_W +: DATA_W]
iTMEMDataRequest  in  NUM_CORES  per-core request level
oTMEMReadData  out  DATA_W  shared response data row
oTMEMDataAvailable  out  NUM_CORES  one-hot, one-cycle response strobe
oMemAddress  out  ADDR_W  backing-memory read address
oMemReadEnable  out  1  one-cycle read command
iMemData  in  DATA_W  backing-memory read data
iMemDataValid  in  1  iMemData valid this cycle
oTimeoutError  out  1  one-cycle pulse when a response was produced by timeout

Behaviour:
- All outputs are registered. Reset values: oTMEMReadData=0, oTMEMDataAvailable=0, oMemAddress=0, oMemReadEnable=0, oTimeoutError=0. On reset: state=IDLE, timeout counter=0, last-served pointer=NUM_CORES-1 (core 0 has first priority), holdoff mask cleared.
- Requester protocol: a core raises its request with a stable address and holds both until it sees its strobe. It may deassert the request one cycle after the strobe.
- Eligible vector = iTMEMDataRequest & ~holdoff. The holdoff bit of the last-served core is set for exactly the one cycle after its strobe. This ignores the request still high from the previous transaction.
- FSM states: IDLE, WAIT, RESPOND.
- IDLE: if any core is eligible, grant the first eligible core searching from (last_served+1) mod NUM_CORES upward, with wrap-around.
  - Latch the grant index and address[ADDR_W-1:0].
  - Next cycle: oMemAddress = latched address, oMemReadEnable=1 for one cycle. Counter cleared. Go to WAIT.
  - If no core is eligible, stay in IDLE.
- WAIT: the counter increments each cycle.
  - If iMemDataValid=1, latch iMemData and go to RESPOND. Valid takes precedence over timeout in the same cycle.
  - Otherwise, when the counter reaches TIMEOUT-1, latch all-zero data, set the timeout flag and go to RESPOND.
- RESPOND (one cycle): oTMEMReadData = latched data. oTMEMDataAvailable[grant] = 1 only if iTMEMDataRequest[grant] is still high; a requester that aborted gets no strobe.
  - oTimeoutError pulses with the response if the timeout flag is set, whether or not the strobe is suppressed.
  - last_served = grant; the holdoff bit is set for grant; go to IDLE.
- oTMEMReadData holds its value until the next response.
- iMemDataValid outside WAIT is ignored. A late return after a timeout is dropped.
- Latency: request sampled in IDLE at cycle t; oMemReadEnable at t+1; memory returning valid at t+1+L (L>=1) gives the strobe at t+3+L.
- One outstanding memory read at a time; there is no pipelining across cores.
- A reset asserted in any state aborts the transaction: no strobe, no error pulse.
- Address bits above ADDR_W are ignored, with no range check.

Test Plan:
- Single request: core 0 requests addr 0x0010; memory returns 0xAAAA_BBBB_CCCC (96-bit, zero-extended) with L=2. Required: oMemReadEnable at t+1 with oMemAddress=0x0010; oTMEMDataAvailable=4'b0001 and oTMEMReadData=that value at t+5; core 0 holding its request at t+6 causes no second read.
- Round-robin fairness: cores 0..3 all request continuously (re-raising after each strobe, addresses 0x100+i) for 8 transactions. Required grant order: 0,1,2,3,0,1,2,3; each strobe is one-hot with the matching data.
- Wrap-around start: last served = 2; cores 0 and 3 request together. Required: core 3 served first, then core 0.
- Timeout: iMemDataValid is never asserted, TIMEOUT=64. Required: strobe with oTMEMReadData=0 and oTimeoutError=1 in the RESPOND cycle (64 WAIT cycles after the read); a valid arriving 3 cycles later produces no strobe.
- Abort: core 1 drops its request while in WAIT; memory then returns valid. Required: no oTMEMDataAvailable bit set; the FSM returns to IDLE and serves the next eligible core normally.
- Reset mid-WAIT: assert Reset for 1 cycle during WAIT. Required: all outputs 0 the next cycle, no strobe; core 0 is served first after release when cores 0 and 2 both request.
